change_dispenser: RTL and testbench

Coin-return block for the vending-machine design: the outgoing end of the coin path. It accepts a change amount in half-yuan units from `selling_machine` and drives one-yuan and half-yuan coin-eject pulses, largest coin first, paced by the slow tick. While dispensing, it shows the remaining change on the 4-digit seven-segment display.

---
 rtl/change_dispenser_if.sv | 17 +
 rtl/change_dispenser.sv | 122 ++++++++++++
 tb/tb_change_dispenser.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, coin-eject and display bundle of the coin-return block
//   master (requester): drives tick, req, amount
//   slave (change_dispenser): drives busy, done, coin_one, coin_half, sel, seg, dp
interface change_dispenser_if;
   logic       tick;
   logic       req;
   logic [3:0] amount;
   logic       busy;
   logic       done;
   logic       coin_one;
   logic       coin_half;
   logic [3:0] sel;
   logic [6:0] seg;
   logic       dp;
   modport master (output tick, req, amount, input busy, done, coin_one, coin_half, sel, seg, dp);
   modport slave (input tick, req, amount, output busy, done, coin_one, coin_half, sel, seg, dp);
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: ejects change as one-yuan coins then at most one half-yuan coin, tick paced
//   clk, clr        : clock, asynchronous active-high reset
//   bus.tick        : slow pacing strobe for pulse/gap timing
//   bus.req/amount  : dispense request and amount in half-yuan units (sampled in IDLE)
//   bus.busy/done   : dispensing in progress / one-clk completion pulse
//   bus.coin_one/half : registered coin-eject pulses
//   bus.sel/seg/dp  : multiplexed 4-digit display of the change still owed
module change_dispenser #(
   parameter int PULSE_TICKS = 2,
   parameter int GAP_TICKS = 1,
   parameter int SCAN_DIV = 50000
) (
   input logic clk,
   input logic clr,
   change_dispenser_if.slave bus
);
   localparam int MAX_TICKS = PULSE_TICKS > GAP_TICKS ? PULSE_TICKS : GAP_TICKS;
   localparam int CW = $clog2(MAX_TICKS + 1);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_TICKS - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   typedef enum logic [2:0] {IDLE, CHOOSE, PULSE, GAP, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0] remain_q, remain_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] scan_q, scan_d;
   logic [1:0] digit_q, digit_d;
   logic one_q, one_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic coin_one_q, coin_one_d;
   logic coin_half_q, coin_half_d;
   function automatic logic [6:0] seg7(input logic [2:0] v);
      case (v)
         3'd0: return 7'b1111110;
         3'd1: return 7'b0110000;
         3'd2: return 7'b1101101;
         3'd3: return 7'b1111001;
         3'd4: return 7'b0110011;
         3'd5: return 7'b1011011;
         3'd6: return 7'b1011111;
         default: return 7'b1110000;
      endcase
   endfunction
   always_comb begin
      state_d = state_q;
      remain_d = remain_q;
      cnt_d = cnt_q;
      one_d = one_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req) begin
               remain_d = bus.amount;
               state_d = CHOOSE;
            end
         end
         CHOOSE: begin
            cnt_d = '0;
            one_d = remain_q >= 4'd2;
            remain_d = remain_q >= 4'd2 ? remain_q - 4'd2 : 4'd0;
            state_d = remain_q == 4'd0 ? DONE : PULSE;
         end
         PULSE: begin
            if (bus.tick) begin
               cnt_d = cnt_q == PULSE_LAST ? '0 : cnt_q + 1'b1;
               state_d = cnt_q == PULSE_LAST ? GAP : PULSE;
            end
         end
         GAP: begin
            if (bus.tick) begin
               cnt_d = cnt_q == GAP_LAST ? '0 : cnt_q + 1'b1;
               state_d = cnt_q == GAP_LAST ? CHOOSE : GAP;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // busy rises one clk after acceptance and drops as DONE is entered
      busy_d = state_q != IDLE && state_d != IDLE && state_d != DONE;
      // done trails the DONE state by one clk so it comes out of a flop
      done_d = state_q == DONE;
      coin_one_d = state_d == PULSE && one_d;
      coin_half_d = state_d == PULSE && !one_d;
      scan_d = scan_q == SCAN_LAST ? '0 : scan_q + 1'b1;
      digit_d = scan_q == SCAN_LAST ? digit_q + 2'd1 : digit_q;
   end
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         remain_q <= '0;
         cnt_q <= '0;
         scan_q <= '0;
         digit_q <= '0;
         one_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         coin_one_q <= 1'b0;
         coin_half_q <= 1'b0;
      end else begin
         state_q <= state_d;
         remain_q <= remain_d;
         cnt_q <= cnt_d;
         scan_q <= scan_d;
         digit_q <= digit_d;
         one_q <= one_d;
         busy_q <= busy_d;
         done_q <= done_d;
         coin_one_q <= coin_one_d;
         coin_half_q <= coin_half_d;
      end
   end
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.coin_one = coin_one_q;
   assign bus.coin_half = coin_half_q;
   assign bus.sel = 4'b0001 << digit_q;
   // digit0 is the half-yuan place, digit1 the whole yuan with the point after it
   assign bus.seg = digit_q == 2'd0 ? (remain_q[0] ? 7'b1011011 : 7'b1111110) :
                    digit_q == 2'd1 ? seg7(remain_q[3:1]) : 7'b0000000;
   assign bus.dp = digit_q == 2'd1;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized self-checking bench for change_dispenser
module tb_change_dispenser;
   localparam int PT = 2;
   localparam int GT = 1;
   logic clk = 1'b0;
   logic clr = 1'b1;
   int tests = 0;
   int fails = 0;
   int obs_coin[$];
   int obs_pt[$];
   int obs_gt[$];
   int done_cnt, done_at, busy_cnt, overlap, post_done, timeout;
   change_dispenser_if bus ();
   change_dispenser #(.PULSE_TICKS(PT), .GAP_TICKS(GT), .SCAN_DIV(4)) dut (.clk(clk), .clr(clr), .bus(bus));
   always #5 clk = ~clk;
   function automatic int count_of(input int v);
      int c = 0;
      foreach (obs_coin[i]) if (obs_coin[i] == v) c++;
      return c;
   endfunction
   function automatic int off_count(input int q[$], input int v);
      int c = 0;
      foreach (q[i]) if (q[i] != v) c++;
      return c;
   endfunction
   // mode 0: tick every 4 clks, 1: random ticks, 2: tick held high
   task automatic dispense(input logic [3:0] amt, input int mode, input bit inject);
      int n = 0;
      int prev = 0;
      int cur;
      int pt = 0;
      int gt = 0;
      bit injected = 0;
      obs_coin.delete();
      obs_pt.delete();
      obs_gt.delete();
      done_cnt = 0; done_at = -1; busy_cnt = 0; overlap = 0; post_done = 0; timeout = 0;
      @(negedge clk);
      bus.amount = amt; bus.req = 1'b1; bus.tick = 1'b0;
      @(negedge clk);
      forever begin
         bus.req = 1'b0;
         cur = bus.coin_one ? 1 : bus.coin_half ? 2 : 0;
         if (bus.coin_one && bus.coin_half) overlap++;
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (done_at < 0) done_at = n;
         end
         if (done_at >= 0 && n > done_at && (bus.busy || cur != 0)) post_done++;
         if (cur != 0 && prev == 0) begin
            obs_coin.push_back(cur);
            if (obs_coin.size() > 1) obs_gt.push_back(gt);
            pt = 0;
         end
         if (cur == 0 && prev != 0) begin
            obs_pt.push_back(pt);
            gt = 0;
         end
         bus.tick = mode == 2 ? 1'b1 : mode == 1 ? ($urandom_range(0, 2) == 0) : (n % 4 == 3);
         if (cur != 0 && bus.tick) pt++;
         if (cur == 0 && obs_coin.size() > 0 && bus.tick) gt++;
         if (inject && !injected && cur != 0) begin
            bus.req = 1'b1; bus.amount = 4'd2; injected = 1;
         end
         prev = cur;
         if ((done_at >= 0 && n >= done_at + 12) || n >= 3000) break;
         @(negedge clk);
         n++;
      end
      if (done_at < 0) timeout = 1;
      bus.tick = 1'b0; bus.req = 1'b0;
   endtask
   task automatic test_reset();
      tests++;
      if ({bus.busy, bus.done, bus.coin_one, bus.coin_half, bus.sel, bus.seg, bus.dp} !== {4'b0000, 4'b0001, 7'b1111110, 1'b0}) begin
         fails++;
         $display("FAIL reset_outputs: got busy=%b done=%b one=%b half=%b sel=%b seg=%b dp=%b, expected 0 0 0 0 0001 1111110 0",
                  bus.busy, bus.done, bus.coin_one, bus.coin_half, bus.sel, bus.seg, bus.dp);
      end
   endtask
   task automatic test_amount7();
      dispense(4'd7, 0, 0);
      tests++; if (timeout !== 0) begin fails++; $display("FAIL a7_timeout: no done seen"); end
      tests++; if (count_of(1) !== 3) begin fails++; $display("FAIL a7_ones: got %0d expected 3", count_of(1)); end
      tests++; if (count_of(2) !== 1) begin fails++; $display("FAIL a7_halves: got %0d expected 1", count_of(2)); end
      tests++; if (obs_coin.size() == 0 || obs_coin[$] !== 2) begin fails++; $display("FAIL a7_order: half coin not last (%0d coins)", obs_coin.size()); end
      tests++; if (obs_pt.size() !== 4 || off_count(obs_pt, PT) !== 0) begin fails++; $display("FAIL a7_pulse_ticks: %0d pulses, %0d of them not %0d ticks", obs_pt.size(), off_count(obs_pt, PT), PT); end
      tests++; if (obs_gt.size() !== 3 || off_count(obs_gt, GT) !== 0) begin fails++; $display("FAIL a7_gap_ticks: %0d gaps, %0d of them not %0d ticks", obs_gt.size(), off_count(obs_gt, GT), GT); end
      tests++; if (done_cnt !== 1) begin fails++; $display("FAIL a7_done_count: got %0d expected 1", done_cnt); end
      tests++; if (overlap !== 0) begin fails++; $display("FAIL a7_overlap: got %0d cycles with both ejects, expected 0", overlap); end
   endtask
   task automatic test_amount0();
      dispense(4'd0, 0, 0);
      tests++; if (done_at !== 2) begin fails++; $display("FAIL a0_done_latency: got %0d expected 2", done_at); end
      tests++; if (busy_cnt !== 0) begin fails++; $display("FAIL a0_busy: got %0d busy cycles expected 0", busy_cnt); end
      tests++; if (obs_coin.size() !== 0) begin fails++; $display("FAIL a0_coins: got %0d expected 0", obs_coin.size()); end
      tests++; if (done_cnt !== 1) begin fails++; $display("FAIL a0_done_count: got %0d expected 1", done_cnt); end
   endtask
   task automatic test_amount15();
      dispense(4'd15, 1, 0);
      tests++; if (count_of(1) !== 7) begin fails++; $display("FAIL a15_ones: got %0d expected 7", count_of(1)); end
      tests++; if (count_of(2) !== 1) begin fails++; $display("FAIL a15_halves: got %0d expected 1", count_of(2)); end
      tests++; if (off_count(obs_pt, PT) !== 0) begin fails++; $display("FAIL a15_pulse_ticks: %0d pulses not %0d ticks", off_count(obs_pt, PT), PT); end
      tests++; if (done_cnt !== 1) begin fails++; $display("FAIL a15_done_count: got %0d expected 1", done_cnt); end
   endtask
   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         logic [3:0] amt;
         int mode;
         amt = 4'($urandom_range(0, 15));
         mode = $urandom_range(0, 2);
         dispense(amt, mode, 0);
         tests++; if (count_of(1) !== amt / 2) begin fails++; $display("FAIL rnd_ones amt=%0d mode=%0d: got %0d expected %0d", amt, mode, count_of(1), amt / 2); end
         tests++; if (count_of(2) !== amt % 2) begin fails++; $display("FAIL rnd_halves amt=%0d mode=%0d: got %0d expected %0d", amt, mode, count_of(2), amt % 2); end
         tests++; if (off_count(obs_pt, PT) !== 0) begin fails++; $display("FAIL rnd_pulse_ticks amt=%0d mode=%0d: %0d pulses not %0d ticks", amt, mode, off_count(obs_pt, PT), PT); end
         tests++; if (done_cnt !== 1) begin fails++; $display("FAIL rnd_done_count amt=%0d mode=%0d: got %0d expected 1", amt, mode, done_cnt); end
         tests++; if (post_done !== 0 || overlap !== 0) begin fails++; $display("FAIL rnd_activity amt=%0d mode=%0d: post-done=%0d overlap=%0d expected 0 0", amt, mode, post_done, overlap); end
      end
   endtask
   task automatic test_req_ignored();
      dispense(4'd5, 0, 1);
      tests++; if (count_of(1) !== 2) begin fails++; $display("FAIL ign_ones: got %0d expected 2", count_of(1)); end
      tests++; if (count_of(2) !== 1) begin fails++; $display("FAIL ign_halves: got %0d expected 1", count_of(2)); end
      tests++; if (done_cnt !== 1) begin fails++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt); end
      tests++; if (post_done !== 0) begin fails++; $display("FAIL ign_second_dispense: got %0d active cycles after done expected 0", post_done); end
   endtask
   task automatic test_display();
      logic [7:0] rec [4];
      int n = 0;
      int bad_sel = 0;
      int low = 0;
      foreach (rec[i]) rec[i] = 8'hxx;
      @(negedge clk);
      bus.amount = 4'd9; bus.req = 1'b1; bus.tick = 1'b0;
      @(negedge clk);
      bus.req = 1'b0;
      while (!bus.coin_one && n < 20) begin @(negedge clk); n++; end
      for (int c = 0; c < 16; c++) begin
         if (!bus.coin_one) low++;
         case (bus.sel)
            4'b0001: rec[0] = {bus.seg, bus.dp};
            4'b0010: rec[1] = {bus.seg, bus.dp};
            4'b0100: rec[2] = {bus.seg, bus.dp};
            4'b1000: rec[3] = {bus.seg, bus.dp};
            default: bad_sel++;
         endcase
         @(negedge clk);
      end
      tests++; if (rec[0] !== {7'b1011011, 1'b0}) begin fails++; $display("FAIL disp_digit0: got seg/dp %b expected 10110110", rec[0]); end
      tests++; if (rec[1] !== {7'b1111001, 1'b1}) begin fails++; $display("FAIL disp_digit1: got seg/dp %b expected 11110011", rec[1]); end
      tests++; if (rec[2] !== 8'h00 || rec[3] !== 8'h00) begin fails++; $display("FAIL disp_blank: got digit2 %b digit3 %b expected 00000000", rec[2], rec[3]); end
      tests++; if (bad_sel !== 0 || low !== 0) begin fails++; $display("FAIL disp_sel_pulse: %0d bad sel, %0d cycles coin_one low, expected 0 0", bad_sel, low); end
      n = 0;
      bus.tick = 1'b1;
      while (!bus.done && n < 500) begin @(negedge clk); n++; end
      bus.tick = 1'b0;
      tests++; if (n >= 500) begin fails++; $display("FAIL disp_finish: done not seen within 500 clks"); end
   endtask
   task automatic test_reset_mid_pulse();
      int n = 0;
      int act = 0;
      @(negedge clk);
      bus.amount = 4'd7; bus.req = 1'b1; bus.tick = 1'b0;
      @(negedge clk);
      bus.req = 1'b0;
      while (!bus.coin_one && n < 50) begin @(negedge clk); n++; end
      tests++; if (n >= 50) begin fails++; $display("FAIL rst_pulse_start: coin_one never rose"); end
      #2 clr = 1'b1;
      #1;
      tests++; if ({bus.coin_one, bus.busy} !== 2'b00) begin fails++; $display("FAIL rst_async_outputs: got one=%b busy=%b expected 0 0", bus.coin_one, bus.busy); end
      tests++; if (dut.remain_q !== 4'd0) begin fails++; $display("FAIL rst_remain: got %0d expected 0", dut.remain_q); end
      repeat (2) @(negedge clk);
      clr = 1'b0;
      tests++; if ({bus.sel, bus.seg} !== {4'b0001, 7'b1111110}) begin fails++; $display("FAIL rst_display: got sel=%b seg=%b expected 0001 1111110", bus.sel, bus.seg); end
      bus.tick = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.coin_one || bus.coin_half || bus.busy || bus.done) act++;
      end
      bus.tick = 1'b0;
      tests++; if (act !== 0) begin fails++; $display("FAIL rst_no_resume: got %0d active cycles expected 0", act); end
   endtask
   initial begin
      bus.tick = 1'b0; bus.req = 1'b0; bus.amount = 4'd0;
      repeat (3) @(negedge clk);
      test_reset();
      clr = 1'b0;
      test_amount7();
      test_amount0();
      test_amount15();
      test_random();
      test_req_ignored();
      test_display();
      test_reset_mid_pulse();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
